// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi222_selctl.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__aoi222_selctl.sv - break-before-make AOI222 leg selector; ERR via GF180MCU_FD_SC_MCU9T5V0__AOI222_SELCTL_ERR_EN
module gf180mcu_fd_sc_mcu9t5v0__aoi222_selctl #(
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       REQ,
    input  logic [1:0] SEL,
    output logic       SA,
    output logic       SB,
    output logic       SC,
    output logic       ACK,
    output logic       BUSY
`ifdef GF180MCU_FD_SC_MCU9T5V0__AOI222_SELCTL_ERR_EN
    ,
    output logic       ERR
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREAK = 2'd1,
        S_MAKE  = 2'd2
    } state_t;

    localparam logic [1:0] LEG_NONE = 2'd3;
    localparam logic [3:0] DEAD_LD  = 4'(DEAD_CYC);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [1:0] r_pend;
    logic [1:0] w_pend_nxt;
    logic [1:0] r_cur;
    logic [1:0] w_cur_nxt;
    logic [2:0] r_en;
    logic [2:0] w_en_nxt;
    logic       r_ack;
    logic       w_ack_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       w_sample;

    // Leg code to one-hot {C,B,A}; code 3 (none) yields all zero
    function automatic logic [2:0] leg_dec(input logic [1:0] leg);
        leg_dec = {leg == 2'd2, leg == 2'd1, leg == 2'd0};
    endfunction

    assign w_sample = (r_state == S_IDLE) && !r_ack && REQ;

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_pend  <= LEG_NONE;
            r_cur   <= LEG_NONE;
            r_en    <= 3'b000;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_cur   <= w_cur_nxt;
            r_en    <= w_en_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sample && (SEL != r_cur)) begin
                    w_state_nxt = (r_cur == LEG_NONE) ? S_MAKE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_MAKE;
                end
            end
            S_MAKE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered: this computes the values loaded on the coming edge
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_pend_nxt = r_pend;
        w_cur_nxt  = r_cur;
        w_en_nxt   = r_en;
        w_ack_nxt  = 1'b0;
        w_busy_nxt = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_sample) begin
                    w_pend_nxt = SEL;
                    if (SEL == r_cur) begin
                        w_ack_nxt = 1'b1;
                    end else if (r_cur == LEG_NONE) begin
                        w_en_nxt  = leg_dec(SEL);
                        w_cur_nxt = SEL;
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_en_nxt   = 3'b000;
                        w_busy_nxt = 1'b1;
                        w_cnt_nxt  = DEAD_LD;
                    end
                end
            end
            S_BREAK: begin
                if (r_cnt <= 4'd1) begin
                    w_en_nxt   = leg_dec(r_pend);
                    w_cur_nxt  = r_pend;
                    w_ack_nxt  = 1'b1;
                    w_busy_nxt = 1'b0;
                    w_cnt_nxt  = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign SA   = r_en[0];
    assign SB   = r_en[1];
    assign SC   = r_en[2];
    assign ACK  = r_ack;
    assign BUSY = r_busy;

`ifdef GF180MCU_FD_SC_MCU9T5V0__AOI222_SELCTL_ERR_EN
    logic r_err;

    // Sticky: a request arriving mid-change is a protocol violation
    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_err <= 1'b0;
        end else if (REQ && r_busy) begin
            r_err <= 1'b1;
        end
    end

    assign ERR = r_err;
`endif

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__aoi222_selctl.md
GF180MCU_FD_SC_MCU9T5V0__AOI222_SELCTL -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__aoi222_selctl

Interface
REQ-001 The block SHALL have parameter DEAD_CYC, default 2, break-before-make dead time in CLK cycles, legal range 1..15.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, named CLK and RN.
REQ-003 Port: CLK  input  1  rising-edge clock.
REQ-004 Port: RN  input  1  synchronous active-low reset.
REQ-005 Port: REQ  input  1  level request to change the selected AOI222 leg.
REQ-006 Port: SEL  input  2  requested leg: 0=A, 1=B, 2=C, 3=none.
REQ-007 Port: SA  output  1  leg-A enable, drives AOI222 A2.
REQ-008 Port: SB  output  1  leg-B enable, drives AOI222 B2.
REQ-009 Port: SC  output  1  leg-C enable, drives AOI222 C2.
REQ-010 Port: ACK  output  1  one-cycle completion pulse.
REQ-011 Port: BUSY  output  1  high while a leg change is in progress.
REQ-012 Port: ERR  output  1  sticky protocol-violation flag; present only with the Configuration macro defined.

Function
REQ-013 SA, SB and SC SHALL be registered and at most one of them SHALL be high in any cycle.
REQ-014 The FSM SHALL have exactly three states: IDLE, BREAK and MAKE.
REQ-015 REQ and SEL SHALL be sampled only in IDLE while ACK=0, and SEL SHALL be captured into a pending register on that edge.
REQ-016 If pending equals the current leg, the FSM SHALL stay in IDLE, leave the enables unchanged, keep BUSY=0 and pulse ACK in the next cycle.
REQ-017 If the current leg is none and pending differs from it, the FSM SHALL go to MAKE directly, with no dead time.
REQ-018 Otherwise, BREAK SHALL deassert all enables and set BUSY=1 from the next cycle onward.
REQ-019 All enables SHALL remain low for exactly DEAD_CYC cycles, timed by a 4-bit down-counter loaded with DEAD_CYC.
REQ-020 MAKE SHALL last one cycle, in which the pending enable is asserted (none if SEL=3), ACK=1, BUSY=0 and the current leg is updated, after which the FSM SHALL return to IDLE.
REQ-021 The latency from the REQ sample edge to ACK high SHALL be DEAD_CYC+1 cycles on the dead-time path and 1 cycle on the other paths.
REQ-022 ACK SHALL be high for exactly one cycle per accepted request.
REQ-023 REQ held high through ACK SHALL be re-sampled in the cycle after ACK.
REQ-024 REQ high while BUSY=1 or ACK=1 SHALL be ignored, and SEL changes during BREAK SHALL NOT affect the pending leg.
REQ-025 Switching from a leg to none (SEL=3) SHALL take the dead-time path.
REQ-026 The enables SHALL NOT change in any cycle other than BREAK entry and MAKE.

Reset
REQ-027 While RN=0 at a CLK edge, the FSM SHALL enter IDLE with SA=SB=SC=0, ACK=0, BUSY=0, ERR=0, current leg=none and counter=0.
REQ-028 Reset asserted mid-BREAK or mid-MAKE SHALL discard the pending request, and no ACK SHALL follow.
REQ-029 The first REQ sample after reset SHALL be on the first edge with RN=1.

Configuration
REQ-030 The macro GF180MCU_FD_SC_MCU9T5V0__AOI222_SELCTL_ERR_EN SHALL control the error feature.
REQ-031 With the macro defined, ERR SHALL exist and SHALL be set on the edge after REQ=1 is seen while BUSY=1.
REQ-032 With the macro defined, ERR SHALL hold until reset, with all other behaviour unchanged.
REQ-033 With the macro undefined, ERR and its register SHALL be absent, and ignored requests SHALL be silent.

Verification
REQ-034 The bench SHALL cover: after reset (leg none), REQ=1 with SEL=0 -> SA=1 and ACK=1 on the next cycle, BUSY never high.
REQ-035 The bench SHALL cover: leg A active, DEAD_CYC=2, REQ with SEL=2 -> SA=0 next cycle, all enables low for 2 cycles, then SC=1 with ACK=1, and no cycle with SA=SC=1.
REQ-036 The bench SHALL cover: leg B active, REQ with SEL=1 -> ACK next cycle, SB stays 1, BUSY=0.
REQ-037 The bench SHALL cover: DEAD_CYC=3, REQ toggled during BREAK with SEL=0 -> ignored, original target asserted at cycle 4, and ERR=1 when the macro is defined.
REQ-038 The bench SHALL cover: RN=0 in the second BREAK cycle -> all outputs 0 next edge, no ACK, and a following REQ with SEL=1 takes the no-dead-time path.
REQ-039 The bench SHALL cover: REQ held high with alternating SEL=0/1 for 20 cycles -> one ACK per transaction, at most one enable high in any cycle, and exactly DEAD_CYC dead cycles between legs.
